// File: rtl/sdm2_mod.sv
// sdm2_mod: second-order delta-sigma modulator, 16-bit unsigned
// samples in, 1-bit density stream out at the modulator clock.
module sdm2_mod #(
  parameter int OSR = 64,
  parameter int IW  = 24
) (
  input  logic        clk_Mfs,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [1:0]  mode,
  output logic        binOut,
  output logic        fs_tick,
  output logic        underrun,
  output logic        ovf
);

  localparam int CW = $clog2(OSR);
  localparam int SW = IW + 2;
  localparam logic [CW-1:0] CMAX = CW'(OSR - 1);

  localparam logic signed [SW-1:0] FB_P = SW'(32768);
  localparam logic signed [SW-1:0] FB_N = -FB_P;
  localparam logic signed [SW-1:0] MAXV =
    {{3{1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{3{1'b1}}, {(IW-1){1'b0}}};

  logic [CW-1:0]          cnt;
  logic                   tick;
  logic [15:0]            x;
  logic [15:0]            x_nrm;
  logic signed [16:0]     e;
  logic                   v;
  logic signed [SW-1:0]   fb;
  logic signed [SW-1:0]   s1;
  logic signed [SW-1:0]   s2;
  logic signed [IW-1:0]   i1;
  logic signed [IW-1:0]   i2;
  logic signed [IW-1:0]   i1_n;
  logic signed [IW-1:0]   i2_n;
  logic                   sat1;
  logic                   sat2;

  assign tick      = (cnt == CMAX);
  assign din_ready = tick;
  assign fs_tick   = tick;

  // Align the selected din field to full scale.
  always_comb begin
    x_nrm = din;
    unique case (1'b1)
      (mode == 2'd0): x_nrm = {din[11:0], 4'b0};
      (mode == 2'd1): x_nrm = {din[8:0], 7'b0};
      default:        x_nrm = din;
    endcase
  end

  // Loop filter: two saturating integrators, 1-bit quantizer.
  always_comb begin
    e  = $signed({1'b0, x}) - 17'sh08000;
    v  = ~i2[IW-1];
    fb = v ? FB_P : FB_N;
    s1 = {{2{i1[IW-1]}}, i1}
       + {{(SW-17){e[16]}}, e}
       - fb;
    sat1 = (s1 > MAXV) || (s1 < MINV);
    if (s1 > MAXV)
      i1_n = MAXV[IW-1:0];
    else if (s1 < MINV)
      i1_n = MINV[IW-1:0];
    else
      i1_n = s1[IW-1:0];
    s2 = {{2{i2[IW-1]}}, i2}
       + {{2{i1_n[IW-1]}}, i1_n}
       - fb;
    sat2 = (s2 > MAXV) || (s2 < MINV);
    if (s2 > MAXV)
      i2_n = MAXV[IW-1:0];
    else if (s2 < MINV)
      i2_n = MINV[IW-1:0];
    else
      i2_n = s2[IW-1:0];
  end

  // Sample-rate counter and sample hold with underrun flag.
  always_ff @(posedge clk_Mfs or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      x        <= 16'h8000;
      underrun <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      underrun <= tick & ~din_valid;
      if (tick && din_valid)
        x <= x_nrm;
    end
  end

  // Integrator state, registered output bit, sticky overflow.
  always_ff @(posedge clk_Mfs or negedge rst) begin
    if (!rst) begin
      i1     <= '0;
      i2     <= '0;
      binOut <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      i1     <= i1_n;
      i2     <= i2_n;
      binOut <= v;
      ovf    <= ovf | sat1 | sat2;
    end
  end

endmodule

// File: tb/tb_sdm2_mod.sv
// tb_sdm2_mod: scoreboard bench for sdm2_mod; windowed
// expectations are queued by stimulus and checked by a monitor.
module tb_sdm2_mod;

  localparam int OSR = 64;

  localparam int SB_ = 0;
  localparam int SU_ = 1;
  localparam int ST_ = 2;
  localparam int SO_ = 3;
  localparam int SG_ = 4;

  logic        clk_Mfs = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [1:0]  mode = 2'd2;
  logic        binOut;
  logic        fs_tick;
  logic        underrun;
  logic        ovf;

  typedef struct {
    string name;
    int    s;
    int    e;
    int    lo;
    int    hi;
    int    sig;
  } item_t;

  item_t sb[$];
  int pb[$];
  int pu[$];
  int pt[$];
  int po[$];
  int pg[$];
  int ns = 0;
  int base = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int a1;
  int a2;

  always #5 clk_Mfs = ~clk_Mfs;

  sdm2_mod #(.OSR(OSR), .IW(24)) dut (
    .clk_Mfs  (clk_Mfs),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .mode     (mode),
    .binOut   (binOut),
    .fs_tick  (fs_tick),
    .underrun (underrun),
    .ovf      (ovf)
  );

  function automatic int win(int sig, int s, int e);
    case (sig)
      SB_:     return pb[e+1] - pb[s];
      SU_:     return pu[e+1] - pu[s];
      ST_:     return pt[e+1] - pt[s];
      SO_:     return po[e+1] - po[s];
      default: return pg[e+1] - pg[s];
    endcase
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic expw(input string n, input int s, input int e,
                      input int lo, input int hi, input int sig);
    item_t it;
    it.name = n;
    it.s = base + s;
    it.e = base + e;
    it.lo = lo;
    it.hi = hi;
    it.sig = sig;
    sb.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_Mfs);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    if (c > cyc)
      step(c - cyc);
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] d,
                       input logic vl);
    rst = 1'b0;
    mode = m;
    din = d;
    din_valid = vl;
    repeat (3) @(posedge clk_Mfs);
    #2;
    rst = 1'b1;
    base = ns;
    cyc = 0;
  endtask

  // Monitor: record one sample per cycle, retire matured windows.
  initial begin
    int g;
    int got;
    pb.push_back(0);
    pu.push_back(0);
    pt.push_back(0);
    po.push_back(0);
    pg.push_back(0);
    forever begin
      @(negedge clk_Mfs);
      a1 = dut.i1;
      a2 = dut.i2;
      g = (a1 > 1048576 || a1 < -1048576 ||
           a2 > 1048576 || a2 < -1048576) ? 1 : 0;
      pb.push_back(pb[ns] + ((binOut === 1'b1) ? 1 : 0));
      pu.push_back(pu[ns] + ((underrun === 1'b1) ? 1 : 0));
      pt.push_back(pt[ns] + ((fs_tick === 1'b1) ? 1 : 0));
      po.push_back(po[ns] + ((ovf === 1'b1) ? 1 : 0));
      pg.push_back(pg[ns] + g);
      ns++;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].e < ns) begin
          got = win(sb[k].sig, sb[k].s, sb[k].e);
          checks++;
          if (got < sb[k].lo || got > sb[k].hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d",
                     sb[k].name, got, sb[k].lo, sb[k].hi);
          end
          sb.delete(k);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int pat[8];
    int lat[7];
    pat = '{1, 0, 0, 1, 1, 0, 0, 1};
    lat = '{0, 1, 1, 0, 1, 1, 0};

    // Idle after reset, midscale hold, stray valid between ticks.
    start(2'd2, 16'h0000, 1'b0);
    expw("rst_binOut", 0, 0, 0, 0, SB_);
    expw("rst_underrun", 0, 0, 0, 0, SU_);
    expw("rst_fs_tick", 0, 0, 0, 0, ST_);
    for (int k = 0; k < 8; k++)
      expw($sformatf("idle_bit%0d", k), k + 1, k + 1,
           pat[k], pat[k], SB_);
    expw("idle_no_tick", 0, OSR - 2, 0, 0, ST_);
    expw("idle_tick1", OSR - 1, OSR - 1, 1, 1, ST_);
    expw("idle_gap", OSR, 2 * OSR - 2, 0, 0, ST_);
    expw("idle_tick2", 2 * OSR - 1, 2 * OSR - 1, 1, 1, ST_);
    expw("idle_no_urun", 0, OSR - 1, 0, 0, SU_);
    expw("idle_urun1", OSR, OSR, 1, 1, SU_);
    expw("idle_urun_len", OSR + 1, OSR + 1, 0, 0, SU_);
    expw("idle_urun2", 2 * OSR, 2 * OSR, 1, 1, SU_);
    expw("idle_urun_cnt", 0, 255, 3, 3, SU_);
    expw("idle_ovf", 0, 299, 0, 0, SO_);
    expw("idle_density", 1, 256, 128, 128, SB_);
    goto(10);
    din_valid = 1'b1;
    goto(62);
    din_valid = 1'b0;
    goto(300);

    // 0.75 full scale: first-use latency and long-run density.
    start(2'd2, 16'd49152, 1'b1);
    for (int k = 0; k < 7; k++)
      expw($sformatf("lat_bit%0d", k), 63 + k, 63 + k,
           lat[k], lat[k], SB_);
    expw("m2_density", 192, 4287, 3068, 3076, SB_);
    expw("m2_ticks", 192, 4287, 64, 64, ST_);
    expw("m2_urun", 0, 4287, 0, 0, SU_);
    expw("m2_ovf", 0, 4287, 0, 0, SO_);
    goto(4300);

    // Narrow modes: upper din bits must be ignored.
    start(2'd0, 16'hF400, 1'b1);
    expw("m0_density", 192, 1215, 252, 260, SB_);
    goto(1230);
    start(2'd1, 16'hFF00, 1'b1);
    expw("m1_density_half", 192, 1215, 508, 516, SB_);
    goto(1230);
    start(2'd1, 16'hFE40, 1'b1);
    expw("m1_density_8th", 192, 1215, 124, 132, SB_);
    goto(1230);

    // Step 0.25 -> 0.75 at tick 319.
    start(2'd2, 16'd16384, 1'b1);
    expw("step_pre", 128, 319, 44, 52, SB_);
    expw("step_post", 576, 1599, 764, 772, SB_);
    expw("step_ovf", 0, 1699, 0, 0, SO_);
    expw("step_bound", 0, 1699, 0, 0, SG_);
    goto(256);
    din = 16'd49152;
    goto(1700);

    // Full scale, then back to midscale.
    start(2'd2, 16'hFFFF, 1'b1);
    expw("fs_density", 100, 4195, 4000, 4096, SB_);
    goto(4200);
    din = 16'd32768;
    expw("fs_recover", 5248, 7295, 1004, 1044, SB_);
    goto(7300);

    // Asynchronous reset mid-stream at cnt = 30.
    start(2'd2, 16'd49152, 1'b1);
    goto(OSR + 30);
    chk("pre_rst_cnt", int'(dut.cnt), 30);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_binOut", int'(binOut), 0);
    chk("arst_underrun", int'(underrun), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_ready", int'(din_ready), 0);
    chk("arst_cnt", int'(dut.cnt), 0);
    chk("arst_x", int'(dut.x), 32768);
    start(2'd2, 16'd49152, 1'b0);
    for (int k = 0; k < 8; k++)
      expw($sformatf("rel_bit%0d", k), k + 1, k + 1,
           pat[k], pat[k], SB_);
    expw("rel_no_tick", 0, OSR - 2, 0, 0, ST_);
    expw("rel_tick1", OSR - 1, OSR - 1, 1, 1, ST_);
    expw("rel_urun1", OSR, OSR, 1, 1, SU_);
    expw("rel_density", 100, 355, 128, 128, SB_);
    goto(400);

    step(4);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unchecked expected checked",
               sb[0].name);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
